wb_stream_loader: RTL and testbench
===================================

WB_STREAM_LOADER -- requirements
Module: wb_stream_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles to wait for wb_ack_i.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 rx_data_i  input  8  received byte from UART receiver.
REQ-005 rx_valid_i  input  1  rx_data_i valid.
REQ-006 rx_ready_o  output  1  loader accepts byte; transfer when rx_valid_i && rx_ready_o.
REQ-007 tx_data_o  output  8  response byte to UART transmitter.
REQ-008 tx_valid_o  output  1  tx_data_o valid.
REQ-009 tx_ready_i  input  1  transmitter accepts byte; transfer when tx_valid_o && tx_ready_i.
REQ-010 wb_addr_o / wb_wdata_o  output  32 / 32  Wishbone master address / write data, driving SoC RAM input port.
REQ-011 wb_rdata_i  input  32  Wishbone read data.
REQ-012 wb_wr_en_o, wb_stb_o, wb_cyc_o  output  1 each  write enable, strobe, cycle.
REQ-013 wb_byte_en_o  output  4  byte enables, always 4'hF during a cycle.
REQ-014 wb_ack_i  input  1  Wishbone acknowledge.

Function
REQ-015 FSM states IDLE, ADDR, DATA, BUS, RESP; rx_ready_o = 1 only in IDLE, ADDR, DATA.
REQ-016 IDLE: accepted byte 0x57 ('W') -> ADDR write mode; 0x52 ('R') -> ADDR read mode; any other -> RESP with single byte 0x15 (NAK).
REQ-017 ADDR: accept 4 bytes MSB first into address shift register; after 4th byte -> DATA (write) or BUS (read).
REQ-018 DATA: accept 4 bytes MSB first into write-data register; after 4th byte -> BUS.
REQ-019 wb_cyc_o, wb_stb_o asserted the cycle after last frame byte accepted; wb_wr_en_o = 1 for write, 0 for read; address/data/byte enables stable while wb_cyc_o high.
REQ-020 BUS: on wb_ack_i sampled high, deassert cyc/stb/wr_en next cycle; read captures wb_rdata_i in that same ack cycle.
REQ-021 Response: write -> single byte 0x06 (ACK); read -> 4 bytes of captured data, MSB first; tx_valid_o asserted the cycle after ack.
REQ-022 tx_data_o held stable while tx_valid_o && !tx_ready_i; byte advances only on transfer; after last byte transfers -> IDLE.
REQ-023 Byte counter 2 bits, wraps 3->0 between ADDR, DATA and RESP phases; never reused without reset to 0 on state entry.
REQ-024 wb_ack_i outside BUS ignored; rx_valid_i outside rx_ready_o ignored (byte not consumed).
REQ-025 Back-to-back frames: new command byte accepted in the cycle after final response byte transfer.

Reset
REQ-026 Async assertion of rst_ni forces IDLE from any state, including mid-frame or mid-bus-cycle.
REQ-027 Reset values: rx_ready_o 1 (IDLE), tx_valid_o 0, tx_data_o 0, wb_cyc_o 0, wb_stb_o 0, wb_wr_en_o 0, wb_byte_en_o 0, wb_addr_o 0, wb_wdata_o 0; counters and shift registers 0.
REQ-028 Partial frames are discarded on reset; no Wishbone cycle issued.

Configuration
REQ-029 Macro WB_STREAM_LOADER_TIMEOUT_EN: when defined, BUS counts cycles; if wb_ack_i not seen within TIMEOUT_CYCLES cycles of cyc assertion, cyc/stb/wr_en deassert next cycle and response is single byte 0x15 (both read and write).
REQ-030 Without WB_STREAM_LOADER_TIMEOUT_EN, no counter is built and BUS waits for wb_ack_i indefinitely.

Verification
REQ-031 Write: bytes 57 02 00 00 10 DE AD BE EF, ack after 3 cycles -> one cycle wb_addr_o=0x02000010, wb_wdata_o=0xDEADBEEF, wb_wr_en_o=1, byte_en=F; tx single byte 0x06.
REQ-032 Read: bytes 52 00 00 00 04, ack with wb_rdata_i=0x12345678 -> wb_wr_en_o=0; tx bytes 12 34 56 78 in order.
REQ-033 Bad command 0x41 -> tx 0x15, no wb_cyc_o assertion, next 0x52 frame processed normally.
REQ-034 tx backpressure: tx_ready_i low 10 cycles during read response -> tx_data_o stable, no byte lost or duplicated.
REQ-035 Reset asserted after 3 address bytes, then full write frame -> only the second frame issues a bus cycle, with its own address.
REQ-036 With WB_STREAM_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16, wb_ack_i held low -> cyc drops after 16 cycles, tx 0x15, FSM returns to IDLE.

Source files
------------

// File: rtl/wb_stream_loader.sv
// Byte-stream to Wishbone loader: 'W' addr[4] data[4] writes a word, 'R' addr[4] reads one back.
// Optional ack timeout is built only when WB_STREAM_LOADER_TIMEOUT_EN is defined.
module wb_stream_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_wdata_o,
    input  logic [31:0] wb_rdata_i,
    output logic        wb_wr_en_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic [3:0]  wb_byte_en_o,
    input  logic        wb_ack_i
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_e;

    state_e      state_q, state_d;
    logic        is_write_q;
    logic        resp_single_q;
    logic [1:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, resp_q;
    logic        rx_fire, tx_fire, bus_ack, timeout;

    assign rx_fire = rx_valid_i && rx_ready_o;
    assign tx_fire = tx_valid_o && tx_ready_i;
    assign bus_ack = (state_q == BUS) && wb_ack_i;

`ifdef WB_STREAM_LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q;

    // Timer is zero on the first cyc cycle, so cyc stays high exactly TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              timer_q <= '0;
        else if (state_q != BUS)  timer_q <= '0;
        else                      timer_q <= timer_q + 1'b1;
    end

    assign timeout = (state_q == BUS) && !wb_ack_i && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (rx_fire) begin
                if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) state_d = ADDR;
                else                                                 state_d = RESP;
            end
            ADDR: if (rx_fire && cnt_q == 2'd3) state_d = is_write_q ? DATA : BUS;
            DATA: if (rx_fire && cnt_q == 2'd3) state_d = BUS;
            BUS:  if (bus_ack || timeout)       state_d = RESP;
            RESP: if (tx_fire && (resp_single_q || cnt_q == 2'd3)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_write_q    <= 1'b0;
            resp_single_q <= 1'b0;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp_q        <= '0;
        end else begin
            // Counter restarts on every phase change instead of relying on the 3->0 wrap.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (((state_q == ADDR || state_q == DATA) && rx_fire) || (state_q == RESP && tx_fire))
                cnt_q <= cnt_q + 2'd1;

            unique case (state_q)
                IDLE: if (rx_fire) begin
                    is_write_q <= (rx_data_i == CMD_WRITE);
                    if (rx_data_i != CMD_WRITE && rx_data_i != CMD_READ) begin
                        resp_q        <= {RSP_NAK, 24'h0};
                        resp_single_q <= 1'b1;
                    end
                end
                ADDR: if (rx_fire) addr_q  <= {addr_q[23:0], rx_data_i};
                DATA: if (rx_fire) wdata_q <= {wdata_q[23:0], rx_data_i};
                BUS: begin
                    if (bus_ack) begin
                        resp_q        <= is_write_q ? {RSP_ACK, 24'h0} : wb_rdata_i;
                        resp_single_q <= is_write_q;
                    end else if (timeout) begin
                        resp_q        <= {RSP_NAK, 24'h0};
                        resp_single_q <= 1'b1;
                    end
                end
                RESP: if (tx_fire) resp_q <= {resp_q[23:0], 8'h00};
                default: ;
            endcase
        end
    end

    assign rx_ready_o   = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign tx_valid_o   = (state_q == RESP);
    assign tx_data_o    = resp_q[31:24];
    assign wb_cyc_o     = (state_q == BUS);
    assign wb_stb_o     = wb_cyc_o;
    assign wb_wr_en_o   = wb_cyc_o && is_write_q;
    assign wb_byte_en_o = wb_cyc_o ? 4'hF : 4'h0;
    assign wb_addr_o    = addr_q;
    assign wb_wdata_o   = wdata_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
// Directed bench for wb_stream_loader: write, read, NAK, backpressure, mid-frame reset, ack timeout.
module tb_wb_stream_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [31:0] wb_addr_o, wb_wdata_o;
    logic [31:0] wb_rdata_i = 32'hDEAD_DEAD;
    logic        wb_wr_en_o, wb_stb_o, wb_cyc_o, wb_ack_i = 1'b0;
    logic [3:0]  wb_byte_en_o;

    int n_pass = 0;
    int n_total = 0;

    wb_stream_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o), .wb_rdata_i(wb_rdata_i),
        .wb_wr_en_o(wb_wr_en_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_byte_en_o(wb_byte_en_o), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Bus monitor on the falling edge: counts cycles, captures the request, flags any wobble.
    int          bus_starts = 0, cyc_cycles = 0, unstable = 0;
    logic        cyc_prev = 1'b0;
    logic [31:0] cap_addr = '0, cap_wdata = '0;
    logic        cap_we = 1'b0;
    logic [3:0]  cap_be = '0;

    always @(negedge clk_i) begin
        if (wb_cyc_o) begin
            if (!cyc_prev) bus_starts++;
            else if (wb_addr_o !== cap_addr || wb_wdata_o !== cap_wdata ||
                     wb_wr_en_o !== cap_we || wb_byte_en_o !== cap_be || wb_stb_o !== 1'b1)
                unstable++;
            cyc_cycles++;
            cap_addr  = wb_addr_o;
            cap_wdata = wb_wdata_o;
            cap_we    = wb_wr_en_o;
            cap_be    = wb_byte_en_o;
        end
        cyc_prev = wb_cyc_o;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
        if (!rx_ready_o) begin
            n_total++;
            $display("FAIL send_byte_timeout: rx_ready_o=%b, required 1", rx_ready_o);
        end else begin
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        tx_ready_i = 1'b1;
        while (!tx_valid_o && n < 50) begin @(posedge clk_i); #1; n++; end
        if (!tx_valid_o) begin
            n_total++;
            $display("FAIL recv_byte_timeout: tx_valid_o=%b, required 1", tx_valid_o);
            b = 8'hxx;
        end else begin
            b = tx_data_o;
            @(posedge clk_i); #1;
        end
        tx_ready_i = 1'b0;
    endtask

    task automatic do_ack(input int delay, input logic [31:0] rdata);
        int n = 0;
        while (!wb_cyc_o && n < 50) begin @(posedge clk_i); #1; n++; end
        repeat (delay) begin @(posedge clk_i); #1; end
        wb_ack_i   = 1'b1;
        wb_rdata_i = rdata;
        @(posedge clk_i); #1;
        wb_ack_i   = 1'b0;
        wb_rdata_i = 32'hDEAD_DEAD;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if ({rx_ready_o, tx_valid_o, tx_data_o, wb_cyc_o, wb_stb_o, wb_wr_en_o, wb_byte_en_o} !== {1'b1, 1'b0, 8'h00, 3'b000, 4'h0})
            $display("FAIL reset_ctrl: got %b, required %b",
                     {rx_ready_o, tx_valid_o, tx_data_o, wb_cyc_o, wb_stb_o, wb_wr_en_o, wb_byte_en_o}, {1'b1, 11'h0, 7'h0});
        else n_pass++;
        n_total++;
        if ({wb_addr_o, wb_wdata_o} !== 64'h0)
            $display("FAIL reset_bus: got %h, required 0", {wb_addr_o, wb_wdata_o});
        else n_pass++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_write();
        int s = bus_starts, c = cyc_cycles;
        logic [7:0] b;
        send_frame(72'h57_02_00_00_10_DE_AD_BE_EF, 9);
        n_total++;
        if (wb_cyc_o !== 1'b1) $display("FAIL wr_cyc_start: got %b, required 1", wb_cyc_o);
        else n_pass++;
        do_ack(3, 32'h0BAD_0BAD);
        n_total++;
        if ({wb_cyc_o, wb_stb_o, wb_wr_en_o, tx_valid_o} !== 4'b0001)
            $display("FAIL wr_after_ack: cyc/stb/we/txv got %b, required 0001", {wb_cyc_o, wb_stb_o, wb_wr_en_o, tx_valid_o});
        else n_pass++;
        n_total++;
        if (bus_starts - s !== 1 || cyc_cycles - c !== 4)
            $display("FAIL wr_bus_count: starts %0d cycles %0d, required 1 and 4", bus_starts - s, cyc_cycles - c);
        else n_pass++;
        n_total++;
        if ({cap_addr, cap_wdata, cap_we, cap_be} !== {32'h0200_0010, 32'hDEAD_BEEF, 1'b1, 4'hF})
            $display("FAIL wr_request: got %h %h %b %h, required 02000010 deadbeef 1 f", cap_addr, cap_wdata, cap_we, cap_be);
        else n_pass++;
        recv_byte(b);
        n_total++;
        if (b !== 8'h06) $display("FAIL wr_resp: got %h, required 06", b);
        else n_pass++;
        n_total++;
        if ({rx_ready_o, tx_valid_o, wb_byte_en_o} !== {1'b1, 1'b0, 4'h0})
            $display("FAIL wr_idle: rx_ready/tx_valid/be got %b, required 1_0_0000", {rx_ready_o, tx_valid_o, wb_byte_en_o});
        else n_pass++;
    endtask

    task automatic test_read(input string name, input logic [31:0] addr, input logic [31:0] data);
        int s = bus_starts;
        logic [7:0] b;
        send_frame({32'h0, 8'h52, addr}, 5);
        do_ack(1, data);
        n_total++;
        if (bus_starts - s !== 1 || cap_addr !== addr || cap_we !== 1'b0 || cap_be !== 4'hF)
            $display("FAIL %s_request: starts %0d addr %h we %b be %h, required 1 %h 0 f", name, bus_starts - s, cap_addr, cap_we, cap_be, addr);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            n_total++;
            if (b !== data[8*(3-i) +: 8]) $display("FAIL %s_byte%0d: got %h, required %h", name, i, b, data[8*(3-i) +: 8]);
            else n_pass++;
        end
        n_total++;
        if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1)
            $display("FAIL %s_idle: tx_valid %b rx_ready %b, required 0 1", name, tx_valid_o, rx_ready_o);
        else n_pass++;
    endtask

    task automatic test_bad_cmd();
        int s = bus_starts;
        logic [7:0] b;
        send_byte(8'h41);
        recv_byte(b);
        n_total++;
        if (b !== 8'h15 || bus_starts - s !== 0)
            $display("FAIL bad_cmd: resp %h starts %0d, required 15 and 0", b, bus_starts - s);
        else n_pass++;
        test_read("after_nak", 32'h0000_0008, 32'hA5C3_5A3C);
    endtask

    task automatic test_ignored_inputs();
        logic [7:0] b;
        wb_ack_i = 1'b1;
        @(posedge clk_i); #1;
        wb_ack_i = 1'b0;
        n_total++;
        if ({wb_cyc_o, rx_ready_o, tx_valid_o} !== 3'b010)
            $display("FAIL stray_ack: cyc/rx_ready/tx_valid got %b, required 010", {wb_cyc_o, rx_ready_o, tx_valid_o});
        else n_pass++;
        send_frame(72'h52_00_00_00_0C, 5);
        rx_data_i  = 8'h41;
        rx_valid_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        rx_valid_i = 1'b0;
        do_ack(0, 32'h0102_0304);
        for (int i = 0; i < 4; i++) recv_byte(b);
        n_total++;
        if (b !== 8'h04 || tx_valid_o !== 1'b0)
            $display("FAIL stray_rx: last byte %h tx_valid %b, required 04 0", b, tx_valid_o);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] b;
        logic stable = 1'b1;
        logic [31:0] data = 32'hCAFE_F00D;
        send_frame(72'h52_00_00_00_20, 5);
        do_ack(2, data);
        repeat (10) begin
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hCA) stable = 1'b0;
            @(posedge clk_i); #1;
        end
        n_total++;
        if (stable !== 1'b1) $display("FAIL bp_hold: stable %b, required 1", stable);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            recv_byte(b);
            n_total++;
            if (b !== data[8*(3-i) +: 8]) $display("FAIL bp_byte%0d: got %h, required %h", i, b, data[8*(3-i) +: 8]);
            else n_pass++;
        end
        n_total++;
        if (tx_valid_o !== 1'b0) $display("FAIL bp_extra: tx_valid %b, required 0", tx_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int s;
        logic [7:0] b;
        send_frame(72'h57_AA_BB_CC, 4);
        #3 rst_ni = 1'b0;
        #1;
        n_total++;
        if ({rx_ready_o, wb_cyc_o, tx_valid_o} !== 3'b100 || wb_addr_o !== 32'h0)
            $display("FAIL midframe_rst: ctrl %b addr %h, required 100 0", {rx_ready_o, wb_cyc_o, tx_valid_o}, wb_addr_o);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        s = bus_starts;
        send_frame(72'h57_00_00_01_00_11_22_33_44, 9);
        do_ack(0, 32'h0);
        n_total++;
        if (bus_starts - s !== 1 || cap_addr !== 32'h0000_0100 || cap_wdata !== 32'h1122_3344 || cap_we !== 1'b1)
            $display("FAIL midframe_frame: starts %0d addr %h data %h we %b, required 1 00000100 11223344 1", bus_starts - s, cap_addr, cap_wdata, cap_we);
        else n_pass++;
        recv_byte(b);
        n_total++;
        if (b !== 8'h06) $display("FAIL midframe_resp: got %h, required 06", b);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_read("b2b_first", 32'h1000_0000, 32'h8899_AABB);
        test_read("b2b_second", 32'h1000_0004, 32'hCCDD_EEFF);
    endtask

`ifdef WB_STREAM_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int c, n = 0;
        logic [7:0] b;
        send_frame(72'h57_00_00_00_30_01_02_03_04, 9);
        c = cyc_cycles;
        while (wb_cyc_o && n < 100) begin @(posedge clk_i); #1; n++; end
        n_total++;
        if (wb_cyc_o !== 1'b0 || cyc_cycles - c !== 16)
            $display("FAIL timeout_cyc: cyc %b cycles %0d, required 0 16", wb_cyc_o, cyc_cycles - c);
        else n_pass++;
        recv_byte(b);
        n_total++;
        if (b !== 8'h15 || rx_ready_o !== 1'b1)
            $display("FAIL timeout_resp: byte %h rx_ready %b, required 15 1", b, rx_ready_o);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read("read", 32'h0000_0004, 32'h1234_5678);
        test_bad_cmd();
        test_ignored_inputs();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
`ifdef WB_STREAM_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        n_total++;
        if (unstable !== 0) $display("FAIL bus_stable: %0d unstable cycles, required 0", unstable);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
